seven_segment_scanner: RTL and testbench

- Time-multiplexed display controller for an N-digit common-anode/cathode seven-segment bank.
- Holds a displayed value and a pending value. Loads are double-buffered and committed only at frame boundaries, so the display never tears.
- Scans the digits in a fixed order with a dark gap between digits (anti-ghosting).
- Feeds each digit's nibble through the existing seven_segment decoder and drives the shared segment bus plus per-digit anode enables.

---
 rtl/seven_seg_pkg.sv | 22 ++
 rtl/seven_segment.sv | 31 +++
 rtl/seven_segment_scanner.sv | 160 ++++++++++++++++
 tb/tb_seven_segment_scanner.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scanner.
package seven_seg_pkg;

    // Scan phases of one digit slot: dark gap, then anode on.
    typedef enum logic {
        S_GAP = 1'b0,
        S_ON  = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK  = 7'h00;
    localparam int         MAX_DIGITS = 8;

    // Anode vector with only digit idx enabled, in the requested polarity.
    function automatic logic [MAX_DIGITS-1:0] an_onehot(input logic [2:0] idx,
                                                        input logic active_low);
        logic [MAX_DIGITS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return active_low ? ~v : v;
    endfunction

endpackage

// File: rtl/seven_segment.sv
// Hex nibble to seven-segment decoder; out = {g,f,e,d,c,b,a}, active-high.
module seven_segment (
    input  logic [3:0] in,
    output logic [6:0] out
);

    // Full hex glyph table, 0-9 then A b C d E F.
    always_comb begin
        out = 7'h00;
        case (in)
            4'h0: out = 7'h3F;
            4'h1: out = 7'h06;
            4'h2: out = 7'h5B;
            4'h3: out = 7'h4F;
            4'h4: out = 7'h66;
            4'h5: out = 7'h6D;
            4'h6: out = 7'h7D;
            4'h7: out = 7'h07;
            4'h8: out = 7'h7F;
            4'h9: out = 7'h6F;
            4'hA: out = 7'h77;
            4'hB: out = 7'h7C;
            4'hC: out = 7'h39;
            4'hD: out = 7'h5E;
            4'hE: out = 7'h79;
            4'hF: out = 7'h71;
            default: out = 7'h00;
        endcase
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment display scanner with frame-aligned
// double-buffered loads, inter-digit dark gaps and leading-zero blanking.
module seven_segment_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int ON_CYCLES     = 1000,
    parameter int GAP_CYCLES    = 16,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    input  logic                    blank_lz,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done
);

    localparam int MAX_CNT = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic             AN_LOW   = (AN_ACTIVE_LOW != 0);

    scan_state_t              state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic                     pend_vld_q;
    logic [4*NUM_DIGITS-1:0]  pend_data_q;
    logic [NUM_DIGITS-1:0]    pend_dp_q;
    logic [4*NUM_DIGITS-1:0]  disp_data_q;
    logic [NUM_DIGITS-1:0]    disp_dp_q;

    logic                     accept;
    logic                     commit;
    logic [NUM_DIGITS-1:0]    lz_blank;
    logic [3:0]               cur_nib;
    logic                     cur_dp;
    logic                     cur_blank;
    logic [6:0]               dec_seg;

    assign frame_done = (state_q == S_ON) && (idx_q == IDX_LAST) && (cnt_q == ON_LAST);
    assign load_ready = !pend_vld_q;
    assign accept     = load_valid && !pend_vld_q;
    assign commit     = frame_done && pend_vld_q;

    // Scan state, digit index and slot counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_GAP;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Slot sequencing: gap then on-time per digit, advancing digit after on-time.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                end
            end
            S_ON: begin
                if (cnt_q == ON_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = S_GAP;
                cnt_d   = '0;
            end
        endcase
    end

    // Pending flag and displayed value; commit only at the frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld_q  <= 1'b0;
            disp_data_q <= '0;
            disp_dp_q   <= '0;
        end else if (commit) begin
            pend_vld_q  <= 1'b0;
            disp_data_q <= pend_data_q;
            disp_dp_q   <= pend_dp_q;
        end else if (accept) begin
            pend_vld_q  <= 1'b1;
        end
    end

    // Pending payload; meaningful only while the pending flag is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_data_q <= load_data;
            pend_dp_q   <= load_dp;
        end
    end

    // Leading-zero map: digit i>0 is blankable when it and all higher digits are 0.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run && (disp_data_q[4*i +: 4] == 4'h0);
            lz_blank[i] = zero_run && (i != 0);
        end
    end

    // Select the nibble, dp bit and blank flag of the digit being scanned.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = disp_data_q[4*i +: 4];
                cur_dp    = disp_dp_q[i];
                cur_blank = lz_blank[i];
            end
        end
    end

    seven_segment u_dec (
        .in  (cur_nib),
        .out (dec_seg)
    );

    // Drive the bus: dark during gaps, selected digit during on-time.
    always_comb begin
        an_out  = {NUM_DIGITS{AN_LOW}};
        seg_out = SEG_BLANK;
        dp_out  = 1'b0;
        if (state_q == S_ON) begin
            an_out  = NUM_DIGITS'(an_onehot(3'(idx_q), AN_LOW));
            seg_out = (blank_lz && cur_blank) ? SEG_BLANK : dec_seg;
            dp_out  = cur_dp;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner (4 digits, ON=4, GAP=2, active-low anodes).
module tb_seven_segment_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = 16'h0;
    logic [3:0]  load_dp = 4'h0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         c;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic       rdy;
    } vec_t;

    vec_t tbl[12];

    seven_segment_scanner #(
        .NUM_DIGITS    (4),
        .ON_CYCLES     (4),
        .GAP_CYCLES    (2),
        .AN_ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_dp    (load_dp),
        .blank_lz   (blank_lz),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .an_out     (an_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        load_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic load_now(input logic [15:0] d, input logic [3:0] dp);
        load_valid = 1'b1;
        load_data  = d;
        load_dp    = dp;
        tick();
        load_valid = 1'b0;
        load_dp    = 4'h0;
    endtask

    task automatic chk_slot(input string name, input logic [3:0] an, input logic [6:0] seg);
        chk({name, "_an"}, 32'(an_out), 32'(an));
        chk({name, "_seg"}, 32'(seg_out), 32'(seg));
    endtask

    initial begin
        int pulses;
        int bad;

        tbl[0]  = '{0,  4'b1111, 7'h00, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1,  4'b1111, 7'h00, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{2,  4'b1110, 7'h3F, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{5,  4'b1110, 7'h3F, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{6,  4'b1111, 7'h00, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{8,  4'b1101, 7'h3F, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{14, 4'b1011, 7'h3F, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{20, 4'b0111, 7'h3F, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{22, 4'b0111, 7'h3F, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{23, 4'b0111, 7'h3F, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{24, 4'b1111, 7'h00, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{47, 4'b0111, 7'h3F, 1'b0, 1'b1, 1'b1};

        // Reset then idle: table-driven frame timing
        rst = 1'b1;
        repeat (2) @(posedge clk);
        do_reset();
        for (int i = 0; i < 12; i++) begin
            run_to(tbl[i].c);
            chk("idle_an",  32'(an_out),     32'(tbl[i].an));
            chk("idle_seg", 32'(seg_out),    32'(tbl[i].seg));
            chk("idle_dp",  32'(dp_out),     32'(tbl[i].dp));
            chk("idle_fd",  32'(frame_done), 32'(tbl[i].fd));
            chk("idle_rdy", 32'(load_ready), 32'(tbl[i].rdy));
        end

        // frame_done pulses exactly at cycles 23, 47, 71
        do_reset();
        pulses = 0;
        bad    = 0;
        for (int c = 0; c < 72; c++) begin
            if (frame_done) begin
                pulses++;
                if (cyc % 24 != 23) bad++;
            end
            tick();
        end
        chk("fd_pulses", 32'(pulses), 32'd3);
        chk("fd_position", 32'(bad), 32'd0);

        // Load 1234 at cycle 3; a held-off request mid-frame is ignored
        do_reset();
        run_to(3);
        chk("l1_rdy3", 32'(load_ready), 32'd1);
        load_now(16'h1234, 4'h0);
        chk("l1_rdy4", 32'(load_ready), 32'd0);
        chk_slot("l1_old_d0", 4'b1110, 7'h3F);
        run_to(10);
        load_valid = 1'b1;
        load_data  = 16'hFFFF;
        run_to(12);
        load_valid = 1'b0;
        run_to(23);
        chk("l1_rdy23", 32'(load_ready), 32'd0);
        tick();
        chk("l1_rdy24", 32'(load_ready), 32'd1);
        run_to(26);
        chk_slot("l1_d0", 4'b1110, 7'h66);
        run_to(32);
        chk_slot("l1_d1", 4'b1101, 7'h4F);
        run_to(38);
        chk_slot("l1_d2", 4'b1011, 7'h5B);
        run_to(44);
        chk_slot("l1_d3", 4'b0111, 7'h06);

        // Back-to-back: accept on frame_done edge, valid held continuously
        do_reset();
        run_to(23);
        chk("b2b_rdy23", 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        load_data  = 16'h00A5;
        tick();
        chk("b2b_rdy24", 32'(load_ready), 32'd0);
        load_data = 16'h2222;
        run_to(26);
        chk_slot("b2b_f2_d0", 4'b1110, 7'h3F);
        run_to(47);
        chk("b2b_rdy47", 32'(load_ready), 32'd0);
        tick();
        chk("b2b_rdy48", 32'(load_ready), 32'd1);
        tick();
        chk("b2b_rdy49", 32'(load_ready), 32'd0);
        load_valid = 1'b0;
        run_to(50);
        chk_slot("b2b_f3_d0", 4'b1110, 7'h6D);
        run_to(56);
        chk_slot("b2b_f3_d1", 4'b1101, 7'h77);
        run_to(62);
        chk_slot("b2b_f3_d2", 4'b1011, 7'h3F);
        run_to(68);
        chk_slot("b2b_f3_d3", 4'b0111, 7'h3F);
        run_to(74);
        chk_slot("b2b_f4_d0", 4'b1110, 7'h5B);

        // Leading-zero blanking
        do_reset();
        blank_lz = 1'b1;
        load_now(16'h0007, 4'h0);
        run_to(2);
        chk_slot("lz0_d0", 4'b1110, 7'h3F);
        run_to(8);
        chk_slot("lz0_d1", 4'b1101, 7'h00);
        run_to(26);
        chk_slot("lz7_d0", 4'b1110, 7'h07);
        run_to(32);
        chk_slot("lz7_d1", 4'b1101, 7'h00);
        run_to(38);
        chk_slot("lz7_d2", 4'b1011, 7'h00);
        run_to(44);
        chk_slot("lz7_d3", 4'b0111, 7'h00);
        load_now(16'h0000, 4'h0);
        run_to(50);
        chk_slot("lzz_d0", 4'b1110, 7'h3F);
        run_to(56);
        chk_slot("lzz_d1", 4'b1101, 7'h00);
        blank_lz = 1'b0;
        tick();
        chk_slot("lz_live_off", 4'b1101, 7'h3F);
        blank_lz = 1'b1;
        load_now(16'h0700, 4'h0);
        run_to(80);
        chk_slot("lzmid_d1", 4'b1101, 7'h3F);
        run_to(86);
        chk_slot("lzmid_d2", 4'b1011, 7'h07);
        run_to(92);
        chk_slot("lzmid_d3", 4'b0111, 7'h00);

        // Decimal point on a blanked digit
        do_reset();
        blank_lz = 1'b1;
        load_now(16'h0000, 4'b0100);
        run_to(32);
        chk("dp_d1", 32'(dp_out), 32'd0);
        run_to(36);
        chk("dp_gap2", 32'(dp_out), 32'd0);
        chk("dp_gap2_an", 32'(an_out), 32'hF);
        run_to(38);
        chk("dp_d2", 32'(dp_out), 32'd1);
        chk_slot("dp_d2", 4'b1011, 7'h00);
        run_to(41);
        chk("dp_d2_last", 32'(dp_out), 32'd1);
        run_to(42);
        chk("dp_gap3", 32'(dp_out), 32'd0);
        run_to(44);
        chk("dp_d3", 32'(dp_out), 32'd0);
        blank_lz = 1'b0;

        // Reset mid-frame with a committed value and a load pending
        do_reset();
        run_to(3);
        load_now(16'h1234, 4'h0);
        run_to(24);
        load_now(16'h5678, 4'hF);
        chk("rst_pend_rdy", 32'(load_ready), 32'd0);
        run_to(26);
        chk_slot("rst_pre_d0", 4'b1110, 7'h66);
        run_to(39);
        do_reset();
        chk("rst_rdy", 32'(load_ready), 32'd1);
        chk_slot("rst_c0", 4'b1111, 7'h00);
        chk("rst_fd", 32'(frame_done), 32'd0);
        chk("rst_dp", 32'(dp_out), 32'd0);
        run_to(2);
        chk_slot("rst_c2", 4'b1110, 7'h3F);
        run_to(22);
        chk("rst_fd22", 32'(frame_done), 32'd0);
        run_to(23);
        chk("rst_fd23", 32'(frame_done), 32'd1);
        run_to(26);
        chk_slot("rst_f2_d0", 4'b1110, 7'h3F);
        chk("rst_f2_dp", 32'(dp_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
